// File: rtl/dcache_flush_ctrl_if.sv
// Flush-controller bundle: flush control, dirty-table scan/write ports and the writeback request.
// slave = the flush controller; master = the cache core, dirty table and writeback unit around it.
interface dcache_flush_ctrl_if #(
  parameter int INDEX_WIDTH = 6
);
  logic                   flush_req;
  logic                   flush_busy;
  logic                   flush_done;
  logic [INDEX_WIDTH+1:0] flush_cnt;
  logic [INDEX_WIDTH-1:0] scan_addr;
  logic [1:0]             scan_dirty;
  logic [1:0]             host_we;
  logic [INDEX_WIDTH-1:0] host_waddr;
  logic                   host_wdata;
  logic [1:0]             dt_we;
  logic [INDEX_WIDTH-1:0] dt_waddr;
  logic                   dt_wdata;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [INDEX_WIDTH-1:0] wb_index;
  logic                   wb_way;

  modport slave (
    input  flush_req, scan_dirty, host_we, host_waddr, host_wdata, wb_ready,
    output flush_busy, flush_done, flush_cnt, scan_addr, dt_we, dt_waddr, dt_wdata,
           wb_valid, wb_index, wb_way
  );

  modport master (
    output flush_req, scan_dirty, host_we, host_waddr, host_wdata, wb_ready,
    input  flush_busy, flush_done, flush_cnt, scan_addr, dt_we, dt_waddr, dt_wdata,
           wb_valid, wb_index, wb_way
  );
endinterface

// File: rtl/dcache_flush_ctrl.sv
// Full D-cache flush sequencer: one set per cycle in SCAN, one writeback plus one dirty clear per dirty way.
// Stalls in WB until wb_ready; host writes always win the dirty-table port and push the clear back a cycle.
module dcache_flush_ctrl #(
  parameter int INDEX_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  dcache_flush_ctrl_if.slave   bus
);

  localparam logic [INDEX_WIDTH-1:0] IDX_MAX = '1;
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE = INDEX_WIDTH'(1);
  localparam logic [INDEX_WIDTH+1:0] CNT_ONE = (INDEX_WIDTH+2)'(1);

  typedef enum logic [2:0] {IDLE, SCAN, WB, CLEAR, DONE} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]             pend_q, pend_d;
  logic [INDEX_WIDTH+1:0] cnt_q, cnt_d;
  logic                   way_q, way_d;
  logic [1:0]             ctrl_we;
  logic                   host_act;
  logic                   wb_way_sel;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      way_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      way_q   <= way_d;
    end
  end

  assign host_act   = |bus.host_we;
  // way0 is always drained first when both ways of a set are dirty
  assign wb_way_sel = ~pend_q[0];

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    pend_d         = pend_q;
    cnt_d          = cnt_q;
    way_d          = way_q;
    ctrl_we        = 2'b00;
    bus.flush_done = 1'b0;
    bus.wb_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = SCAN;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (bus.scan_dirty != 2'b00) begin
          pend_d  = bus.scan_dirty;
          state_d = WB;
        end else if (idx_q == IDX_MAX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      WB: begin
        bus.wb_valid = 1'b1;
        if (bus.wb_ready) begin
          pend_d[wb_way_sel] = 1'b0;
          way_d              = wb_way_sel;
          cnt_d              = cnt_q + CNT_ONE;
          state_d            = CLEAR;
        end
      end
      CLEAR: begin
        if (!host_act) begin
          ctrl_we = way_q ? 2'b10 : 2'b01;
          if (pend_q != 2'b00) begin
            state_d = WB;
          end else if (idx_q == IDX_MAX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        bus.flush_done = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.flush_busy = (state_q != IDLE);
  assign bus.flush_cnt  = cnt_q;
  assign bus.scan_addr  = idx_q;
  assign bus.wb_index   = idx_q;
  assign bus.wb_way     = wb_way_sel;

  assign bus.dt_we    = host_act ? bus.host_we    : ctrl_we;
  assign bus.dt_waddr = host_act ? bus.host_waddr : idx_q;
  assign bus.dt_wdata = host_act ? bus.host_wdata : 1'b0;

endmodule
